// File: rtl/duty_pkg.sv
// Shared duty-code definitions for the pulse-channel generator and decoder.
package duty_pkg;

  localparam int WINDOW = 8;

  localparam logic [1:0] DUTY_125 = 2'd0;
  localparam logic [1:0] DUTY_250 = 2'd1;
  localparam logic [1:0] DUTY_500 = 2'd2;
  localparam logic [1:0] DUTY_750 = 2'd3;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_TRACK,
    ST_LOCKED
  } dec_state_e;

  // Number of high samples per WINDOW-sample period for each duty code.
  function automatic logic [3:0] duty_popcount(input logic [1:0] code);
    case (code)
      DUTY_125: duty_popcount = 4'd1;
      DUTY_250: duty_popcount = 4'd2;
      DUTY_500: duty_popcount = 4'd4;
      default:  duty_popcount = 4'd6;
    endcase
  endfunction

endpackage

// File: rtl/duty_decoder_if.sv
// Sample strobe / wave input and recovered-duty status outputs of the duty decoder.
interface duty_decoder_if;
  logic       step;
  logic       wave_in;
  logic [1:0] duty_cycle;
  logic       locked;
  logic       period_valid;
  logic       error;

  modport master (
    output step, wave_in,
    input  duty_cycle, locked, period_valid, error
  );

  modport slave (
    input  step, wave_in,
    output duty_cycle, locked, period_valid, error
  );
endinterface

// File: rtl/duty_classify.sv
// Rotation-invariant classifier: one circular high run whose length matches a duty code.
module duty_classify
  import duty_pkg::*;
(
  input  logic [WINDOW-1:0] w_i,
  output logic              legal_o,
  output logic [1:0]        code_o
);

  logic [WINDOW-1:0] w_rot;
  logic [WINDOW-1:0] edge_mask;
  logic [3:0]        pop;
  logic [3:0]        rise_cnt;

  // w_rot[i] is the sample taken just before w_i[i], wrapping oldest to newest.
  assign w_rot     = {w_i[0], w_i[WINDOW-1:1]};
  assign edge_mask = w_i & ~w_rot;

  always_comb begin
    pop      = 4'd0;
    rise_cnt = 4'd0;
    legal_o  = 1'b0;
    code_o   = 2'd0;
    for (int i = 0; i < WINDOW; i++) begin
      pop      = pop + {3'd0, w_i[i]};
      rise_cnt = rise_cnt + {3'd0, edge_mask[i]};
    end
    for (int c = 0; c < 4; c++) begin
      if (pop == duty_popcount(c[1:0])) begin
        legal_o = (rise_cnt == 4'd1);
        code_o  = c[1:0];
      end
    end
  end

endmodule

// File: rtl/duty_decoder.sv
// Recovers the 2-bit duty code from a strobed square wave, one evaluation per 8 samples,
// and reports lock once the same code repeats for LOCK_PERIODS periods.
module duty_decoder
  import duty_pkg::*;
#(
  parameter int LOCK_PERIODS = 2
) (
  input  logic           clk,
  input  logic           reset,
  duty_decoder_if.slave  bus
);

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_PERIODS);

  dec_state_e  state_q;
  logic [7:0]  hist_q;
  logic [7:0]  hist_d;
  logic [2:0]  phase_q;
  logic [3:0]  match_cnt_q;
  logic [3:0]  match_cnt_d;
  logic [1:0]  duty_q;
  logic        locked_q;
  logic        valid_q;
  logic        error_q;
  logic        eval;
  logic        legal;
  logic [1:0]  code;

  assign hist_d      = {hist_q[6:0], bus.wave_in};
  assign eval        = bus.step && (phase_q == 3'd7);
  assign match_cnt_d = (match_cnt_q >= LOCK_CNT) ? LOCK_CNT : match_cnt_q + 4'd1;

  duty_classify u_classify (
    .w_i     (hist_d),
    .legal_o (legal),
    .code_o  (code)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FILL;
      hist_q      <= 8'd0;
      phase_q     <= 3'd0;
      match_cnt_q <= 4'd0;
      duty_q      <= 2'd0;
      locked_q    <= 1'b0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      if (bus.step) begin
        hist_q  <= hist_d;
        phase_q <= phase_q + 3'd1;
      end
      if (eval) begin
        if (!legal) begin
          error_q     <= 1'b1;
          match_cnt_q <= 4'd0;
          locked_q    <= 1'b0;
          state_q     <= ST_TRACK;
        end else begin
          valid_q <= 1'b1;
          case (state_q)
            ST_FILL: begin
              duty_q      <= code;
              match_cnt_q <= 4'd1;
              if (LOCK_CNT == 4'd1) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
              end else begin
                state_q  <= ST_TRACK;
              end
            end
            ST_TRACK: begin
              if (code == duty_q) begin
                match_cnt_q <= match_cnt_d;
                if (match_cnt_d >= LOCK_CNT) begin
                  state_q  <= ST_LOCKED;
                  locked_q <= 1'b1;
                end
              end else begin
                duty_q      <= code;
                match_cnt_q <= 4'd1;
                if (LOCK_CNT == 4'd1) begin
                  state_q  <= ST_LOCKED;
                  locked_q <= 1'b1;
                end
              end
            end
            ST_LOCKED: begin
              // A new legal code restarts tracking even when one period would suffice.
              if (code == duty_q) begin
                match_cnt_q <= match_cnt_d;
              end else begin
                duty_q      <= code;
                match_cnt_q <= 4'd1;
                locked_q    <= 1'b0;
                state_q     <= ST_TRACK;
              end
            end
            default: begin
              state_q  <= ST_FILL;
              locked_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign bus.duty_cycle   = duty_q;
  assign bus.locked       = locked_q;
  assign bus.period_valid = valid_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_duty_decoder.sv
// Directed bench for duty_decoder: periods sent MSB-first, checked on the 8th step.
module tb_duty_decoder;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_bad = 0;

  duty_decoder_if bus ();

  duty_decoder #(.LOCK_PERIODS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic w);
    bus.step    = s;
    bus.wave_in = w;
    @(posedge clk);
    #1;
  endtask

  // Sends one 8-sample period; gap idle cycles (with wave toggled) follow each step.
  task automatic period(input string tag, input logic [7:0] pat, input int gap,
                        input logic epv, input logic eerr, input logic [1:0] edc,
                        input logic elock);
    for (int i = 7; i >= 0; i--) begin
      cyc(1'b1, pat[i]);
      if (i == 7)
        chk({tag, ".idle"}, {6'd0, bus.period_valid, bus.error}, 8'd0);
      if (i == 0) begin
        chk({tag, ".pv"},   {7'd0, bus.period_valid}, {7'd0, epv});
        chk({tag, ".err"},  {7'd0, bus.error},        {7'd0, eerr});
        chk({tag, ".duty"}, {6'd0, bus.duty_cycle},   {6'd0, edc});
        chk({tag, ".lock"}, {7'd0, bus.locked},       {7'd0, elock});
      end
      for (int g = 0; g < gap; g++)
        cyc(1'b0, ~pat[i]);
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    cyc(1'b1, 1'b1);
    chk({tag, ".outs"}, {3'd0, bus.duty_cycle, bus.locked, bus.period_valid, bus.error}, 8'd0);
    cyc(1'b1, 1'b1);
    reset = 1'b0;
    cyc(1'b0, 1'b0);
  endtask

  initial begin
    reset       = 1'b1;
    bus.step    = 1'b0;
    bus.wave_in = 1'b0;
    do_reset("rst0");

    // Continuous step, code 2 locks after second period.
    period("c2a", 8'b10000111, 0, 1'b1, 1'b0, 2'd2, 1'b0);
    period("c2b", 8'b10000111, 0, 1'b1, 1'b0, 2'd2, 1'b1);
    period("c2c", 8'b10000111, 0, 1'b1, 1'b0, 2'd2, 1'b1);

    // Illegal pattern while locked, then relock.
    period("alt", 8'b10101010, 0, 1'b0, 1'b1, 2'd2, 1'b0);
    period("r2a", 8'b10000111, 0, 1'b1, 1'b0, 2'd2, 1'b0);
    period("r2b", 8'b10000111, 0, 1'b1, 1'b0, 2'd2, 1'b1);

    // Walk through codes 3, 0, 1.
    period("c3a", 8'b01111110, 0, 1'b1, 1'b0, 2'd3, 1'b0);
    period("c3b", 8'b01111110, 0, 1'b1, 1'b0, 2'd3, 1'b1);
    period("c0a", 8'b00000001, 0, 1'b1, 1'b0, 2'd0, 1'b0);
    period("c0b", 8'b00000001, 0, 1'b1, 1'b0, 2'd0, 1'b1);
    period("c1a", 8'b10000001, 0, 1'b1, 1'b0, 2'd1, 1'b0);
    period("c1b", 8'b10000001, 0, 1'b1, 1'b0, 2'd1, 1'b1);
    period("c1rot", 8'b00011000, 0, 1'b1, 1'b0, 2'd1, 1'b1);

    // Sparse strobe: one step every third clock, wave toggled between steps.
    do_reset("rst1");
    period("sp1a", 8'b10000001, 2, 1'b1, 1'b0, 2'd1, 1'b0);
    period("sp1b", 8'b10000001, 2, 1'b1, 1'b0, 2'd1, 1'b1);

    // Degenerate inputs.
    period("zero0", 8'b00000000, 0, 1'b0, 1'b1, 2'd1, 1'b0);
    period("zero1", 8'b00000000, 0, 1'b0, 1'b1, 2'd1, 1'b0);
    period("ones",  8'b11111111, 0, 1'b0, 1'b1, 2'd1, 1'b0);
    period("pop3",  8'b00000111, 0, 1'b0, 1'b1, 2'd1, 1'b0);

    // Lock, reset while locked, relock in 16 steps.
    period("l2a", 8'b10000111, 0, 1'b1, 1'b0, 2'd2, 1'b0);
    period("l2b", 8'b10000111, 0, 1'b1, 1'b0, 2'd2, 1'b1);
    do_reset("rst2");
    period("f2a", 8'b10000111, 0, 1'b1, 1'b0, 2'd2, 1'b0);
    period("f2b", 8'b10000111, 0, 1'b1, 1'b0, 2'd2, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
